// File: rtl/rocket_trace_arbiter.sv
// Merges per-core retire-trace streams into one tagged stream. Each core has an elastic FIFO.
// A round-robin arbiter feeds a single output register that carries a global merge-order sequence number.
module rocket_trace_arbiter #(
    parameter int N_CORES    = 4,
    parameter int PC_W       = 64,
    parameter int INSN_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_W      = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [N_CORES-1:0]           req_valid,
    output logic [N_CORES-1:0]           req_ready,
    input  logic [N_CORES*PC_W-1:0]      req_pc,
    input  logic [N_CORES*INSN_W-1:0]    req_insn,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(N_CORES)-1:0]   out_core_id,
    output logic [PC_W-1:0]              out_pc,
    output logic [INSN_W-1:0]            out_insn,
    output logic [SEQ_W-1:0]             out_seq,
    output logic                         idle
);
    localparam int CW   = $clog2(N_CORES);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    logic [N_CORES-1:0]             nonempty, push, pop, empty_d;
    logic [N_CORES-1:0][PC_W-1:0]   head_pc;
    logic [N_CORES-1:0][INSN_W-1:0] head_insn;

    logic [CW-1:0]  last_q, winner, scan_idx;
    logic           found, load, out_valid_d;
    logic           out_valid_q, idle_q;
    logic [CW-1:0]  out_core_id_q;
    logic [PC_W-1:0]   out_pc_q;
    logic [INSN_W-1:0] out_insn_q;
    logic [SEQ_W-1:0]  out_seq_q, seq_cnt_q;

    for (genvar g = 0; g < N_CORES; g++) begin : g_core
        logic [PC_W+INSN_W-1:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0]          wr_q, rd_q;
        logic [CNTW-1:0]        cnt_q, cnt_d;
        logic                   rdy_q;

        assign push[g]      = req_valid[g] & rdy_q;
        assign pop[g]       = load && (winner == CW'(g));
        assign nonempty[g]  = (cnt_q != '0);
        assign empty_d[g]   = (cnt_d == '0);
        assign req_ready[g] = rdy_q;
        assign {head_pc[g], head_insn[g]} = mem_q[rd_q];

        always_comb begin
            cnt_d = cnt_q;
            if (push[g] && !pop[g])      cnt_d = cnt_q + CNTW'(1);
            else if (!push[g] && pop[g]) cnt_d = cnt_q - CNTW'(1);
        end

        // Ready is registered from the next count, so a full FIFO stays unready through its pop cycle.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
                rdy_q <= 1'b0;
            end else begin
                if (push[g]) wr_q <= wr_q + AW'(1);
                if (pop[g])  rd_q <= rd_q + AW'(1);
                cnt_q <= cnt_d;
                rdy_q <= (cnt_d != CNTW'(FIFO_DEPTH));
            end
        end

        always_ff @(posedge clock) begin
            if (push[g]) mem_q[wr_q] <= {req_pc[g*PC_W +: PC_W], req_insn[g*INSN_W +: INSN_W]};
        end
    end

    // Round-robin scan starting just after the last granted core.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 1; k <= N_CORES; k++) begin
            scan_idx = CW'((int'(last_q) + k) % N_CORES);
            if (!found && nonempty[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign load        = found && (!out_valid_q || out_ready);
    assign out_valid_d = load || (out_valid_q && !out_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q   <= 1'b0;
            out_core_id_q <= '0;
            out_pc_q      <= '0;
            out_insn_q    <= '0;
            out_seq_q     <= '0;
            seq_cnt_q     <= '0;
            last_q        <= CW'(N_CORES - 1);
            idle_q        <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            if (load) begin
                out_core_id_q <= winner;
                out_pc_q      <= head_pc[winner];
                out_insn_q    <= head_insn[winner];
                out_seq_q     <= seq_cnt_q;
                seq_cnt_q     <= seq_cnt_q + SEQ_W'(1);
                last_q        <= winner;
            end
            idle_q <= (&empty_d) && !out_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_core_id = out_core_id_q;
    assign out_pc      = out_pc_q;
    assign out_insn    = out_insn_q;
    assign out_seq     = out_seq_q;
    assign idle        = idle_q;
endmodule

// File: tb/tb_rocket_trace_arbiter.sv
// Directed checks of rocket_trace_arbiter: reset, latency, ordering, backpressure, fairness, seq wrap, mid-stream reset.
module tb_rocket_trace_arbiter;
    localparam int N = 4, PW = 64, IW = 32, D = 4, SW = 4;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*PW-1:0] req_pc;
    logic [N*IW-1:0] req_insn;
    logic            out_valid, out_ready, idle;
    logic [1:0]      out_core_id;
    logic [PW-1:0]   out_pc;
    logic [IW-1:0]   out_insn;
    logic [SW-1:0]   out_seq;

    int n_chk = 0, n_fail = 0;

    rocket_trace_arbiter #(.N_CORES(N), .PC_W(PW), .INSN_W(IW), .FIFO_DEPTH(D), .SEQ_W(SW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc), .req_insn(req_insn),
        .out_valid(out_valid), .out_ready(out_ready), .out_core_id(out_core_id),
        .out_pc(out_pc), .out_insn(out_insn), .out_seq(out_seq), .idle(idle)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int c, input logic [63:0] pc, input logic [31:0] insn);
        req_valid[c]         = 1'b1;
        req_pc[c*PW +: PW]   = pc;
        req_insn[c*IW +: IW] = insn;
    endtask

    task automatic do_reset();
        req_valid = '0;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        #1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int sent;
        logic rdy;
        req_valid = '0; req_pc = '0; req_insn = '0; out_ready = 1'b1;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_seq", out_seq, 0);
        chk("rst_pc", out_pc, 0);
        tick();
        reset_n = 1'b1;
        chk("rel_ready0", req_ready, 0);
        tick();
        chk("rel_ready1", req_ready, 4'hF);

        // single event, 2-cycle latency
        drive(2, 64'h8000_0000, 32'h13);
        tick();
        req_valid = '0;
        chk("se_valid_e", out_valid, 0);
        chk("se_idle_e", idle, 0);
        tick();
        chk("se_valid", out_valid, 1);
        chk("se_id", out_core_id, 2);
        chk("se_pc", out_pc, 64'h8000_0000);
        chk("se_insn", out_insn, 32'h13);
        chk("se_seq", out_seq, 0);
        chk("se_idle", idle, 0);
        tick();
        chk("se_valid_end", out_valid, 0);
        chk("se_idle_end", idle, 1);

        // simultaneous start
        do_reset();
        for (int c = 0; c < N; c++) drive(c, 64'h1000 + c, 32'h100 + c);
        tick();
        req_valid = '0;
        for (int k = 0; k < N; k++) begin
            tick();
            chk("sim_valid", out_valid, 1);
            chk("sim_id", out_core_id, k);
            chk("sim_seq", out_seq, k);
            chk("sim_pc", out_pc, 64'h1000 + k);
        end
        tick();
        chk("sim_valid_end", out_valid, 0);

        // backpressure on core 1
        do_reset();
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1, 64'h2000 + sent, 32'h200 + sent);
            rdy = req_ready[1];
            tick();
            if (rdy) sent++;
            if (c >= 2) chk("bp_stable_pc", out_pc, 64'h2000);
        end
        req_valid = '0;
        chk("bp_accepts", sent, 5);
        chk("bp_ready_low", req_ready[1], 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_seq_hold", out_seq, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_drain_valid", out_valid, 1);
            chk("bp_drain_pc", out_pc, 64'h2000 + k);
            chk("bp_drain_insn", out_insn, 32'h200 + k);
            chk("bp_drain_seq", out_seq, k);
            tick();
            if (k == 0) chk("bp_ready_back", req_ready[1], 1);
        end
        chk("bp_drain_end", out_valid, 0);

        // fairness between cores 0 and 3
        do_reset();
        drive(0, 64'h3000, 32'h300);
        drive(3, 64'h3300, 32'h330);
        tick();
        for (int k = 0; k < 19; k++) begin
            tick();
            chk("fair_valid", out_valid, 1);
            chk("fair_id", out_core_id, (k % 2 == 0) ? 0 : 3);
        end
        req_valid = '0;

        // seq wrap with a 4-bit counter
        do_reset();
        for (int c = 0; c <= 18; c++) begin
            if (c < 18) drive(2, 64'h4000 + c, 32'h400 + c);
            else req_valid = '0;
            tick();
            if (c >= 1) begin
                chk("wrap_seq", out_seq, (c - 1) % 16);
                chk("wrap_pc", out_pc, 64'h4000 + c - 1);
            end
        end

        // reset mid-stream: 3 buffered, 1 held in output
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1, 64'h5000 + c, 32'h500 + c);
            tick();
        end
        req_valid = '0;
        chk("mr_pre_valid", out_valid, 1);
        chk("mr_pre_id", out_core_id, 1);
        reset_n = 1'b0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_ready", req_ready, 0);
        chk("mr_idle", idle, 1);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        drive(0, 64'h6000, 32'h600);
        drive(3, 64'h6300, 32'h630);
        tick();
        req_valid = '0;
        tick();
        chk("mr_first_id", out_core_id, 0);
        chk("mr_first_seq", out_seq, 0);
        chk("mr_first_pc", out_pc, 64'h6000);
        tick();
        chk("mr_second_id", out_core_id, 3);
        chk("mr_second_seq", out_seq, 1);
        tick();
        chk("mr_end_valid", out_valid, 0);
        chk("mr_end_idle", idle, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rocket_trace_arbiter.md
Name: rocket_trace_arbiter

Overview:
- Merges the per-core instruction-retire trace streams of the four Rocket cores in the SoC subsystem into one tagged stream.
- The single output stream feeds the testbench monitor/scoreboard.
- Each core has its own elastic FIFO. A round-robin arbiter shares the single output channel fairly, and a global sequence number records the merged order.

Parameters:
- N_CORES, 4, number of requesting cores (2..8)
- PC_W, 64, program counter width
- INSN_W, 32, instruction word width
- FIFO_DEPTH, 4, entries per core FIFO (power of 2, >=2)
- SEQ_W, 16, width of the output sequence counter

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  N_CORES  per-core event valid
- req_ready  out  N_CORES  per-core FIFO not full
- req_pc  in  N_CORES*PC_W  per-core retired PC; core i occupies bits [i*PC_W +: PC_W]
- req_insn  in  N_CORES*INSN_W  per-core retired instruction, same packing as req_pc
- out_valid  out  1  merged event valid
- out_ready  in  1  consumer accept
- out_core_id  out  $clog2(N_CORES)  source core of the event
- out_pc  out  PC_W  event PC
- out_insn  out  INSN_W  event instruction
- out_seq  out  SEQ_W  global merge-order sequence number
- idle  out  1  all FIFOs empty and out_valid low

Behaviour:
- Reset, asynchronous on reset_n low. While reset is asserted:
  - all FIFOs are empty, and req_ready = 0;
  - out_valid = 0; out_core_id, out_pc, out_insn and out_seq = 0;
  - last_grant = N_CORES-1, so core 0 has top priority first;
  - idle = 1.
- req_ready:
  - registered; equals !full of that core's FIFO;
  - first goes to 1 in the cycle after reset_n deasserts;
  - never depends combinationally on req_valid.
- Push: occurs on the rising edge where req_valid[i] && req_ready[i]. The FIFO captures {pc, insn}.
- Full FIFO: no bypass. A full FIFO holds req_ready low even in a cycle where it is popped; req_ready rises the cycle after the pop.
- Output register:
  - loads when (!out_valid || out_ready) and at least one FIFO is non-empty;
  - while out_valid && !out_ready, out_core_id, out_pc, out_insn and out_seq stay stable;
  - if nothing loads while the slot is free or being consumed, out_valid = 0 the next cycle.
- Arbitration, combinational over the FIFO non-empty flags:
  - the winner is the first non-empty core scanning last_grant+1, last_grant+2, ... modulo N_CORES;
  - on load, the winner's FIFO pops and last_grant takes the winner's index;
  - last_grant changes only on a load.
- Fairness: with K cores continuously non-empty and out_ready = 1, each core wins exactly once every K loads.
- Latency: an event accepted at edge E into an empty FIFO, with the output free and no competitor, gives out_valid = 1 after edge E+1 (2-cycle minimum). Throughput is 1 event per cycle when out_ready = 1.
- out_seq:
  - increments by 1 on every output load; the first event after reset carries 0;
  - wraps from 2^SEQ_W-1 to 0 with no flag.
- Per-core FIFO:
  - circular, with a log2(FIFO_DEPTH)+1-bit count;
  - a simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged;
  - a push and pop on an empty FIFO in the same cycle cannot occur, because there is no bypass.
- idle: registered, = (all counts == 0) && !out_valid.
- Reset mid-operation: all buffered and in-flight events are discarded and no partial output is produced. After release, behaviour is identical to first reset, with seq restarting at 0.

Test Plan:
- Single event: after reset, core 2 pushes pc=0x8000_0000, insn=0x0000_0013 at edge E, out_ready = 1 -> out_valid after edge E+1 with core_id=2, that pc/insn and seq=0. idle = 0 for 2 cycles, then returns to 1.
- Simultaneous start: all 4 cores push one event in the same cycle right after reset -> output order core 0,1,2,3, seq 0,1,2,3, on consecutive cycles.
- Backpressure:
  - setup: out_ready = 0 for 10 cycles while core 1 streams every cycle;
  - req_ready[1] drops after 4 accepts, plus 1 held in the output register;
  - payload stays stable;
  - on release, 5 events drain in order with no loss or duplication.
- Fairness: cores 0 and 3 continuously valid, out_ready = 1, 20 cycles -> strict alternation 0,3,0,3. No core is granted twice in a row while the other is non-empty.
- Seq wrap: with SEQ_W=4, stream 18 events -> out_seq runs 0..15, 0, 1.
- Reset mid-stream: assert reset_n low with 3 events buffered and out_valid = 1 -> out_valid = 0 and req_ready = 0 immediately. After release, the next event carries seq=0 and core 0 has top priority.
